pwm_from_counter: RTL

//   Downstream consumer of the free-running modulo counter (contagem/fim). Turns the counter

---
 rtl/pwm_from_counter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/pwm_from_counter.sv
`default_nettype none
// ============================================================================
// Module      : pwm_from_counter
// Description : PWM generator driven by an upstream modulo counter, with a
//               double-buffered duty config and period-aligned start/stop.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_from_counter #(
  parameter int WIDTH  = 5,
  parameter int PCNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [WIDTH-1:0]  contagem,
  input  logic              fim,
  input  logic [WIDTH:0]    cfg_duty,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              pwm,
  output logic              period_done,
  output logic              busy,
  output logic [PCNT_W-1:0] period_cnt
);

  localparam logic [PCNT_W-1:0] c_pcnt_one = 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ARMED    = 2'd1,
    S_RUN      = 2'd2,
    S_STOPPING = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [WIDTH:0]    r_duty_active;
  logic [WIDTH:0]    r_duty_pending;
  logic              r_pending_valid;
  logic              r_pwm;
  logic              r_period_done;
  logic [PCNT_W-1:0] r_period_cnt;

  logic w_running;
  logic w_next_running;
  logic w_accept;
  logic w_apply;
  logic w_pwm_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Re-enabling during STOPPING wins over fim so a period boundary never drops a pulse.
  always_comb begin
    w_state_next   = r_state;
    w_running      = 1'b0;
    w_next_running = 1'b0;
    w_accept       = 1'b0;
    w_apply        = 1'b0;
    w_pwm_next     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (enable) w_state_next = S_ARMED;
      end
      S_ARMED: begin
        if (fim) w_state_next = enable ? S_RUN : S_IDLE;
      end
      S_RUN: begin
        if (!enable) w_state_next = fim ? S_IDLE : S_STOPPING;
      end
      S_STOPPING: begin
        if (enable) begin
          w_state_next = S_RUN;
        end else if (fim) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    w_running      = (r_state == S_RUN) || (r_state == S_STOPPING);
    w_next_running = (w_state_next == S_RUN) || (w_state_next == S_STOPPING);
    w_accept       = cfg_valid && !r_pending_valid;
    w_apply        = r_pending_valid && (fim || (r_state == S_IDLE));
    w_pwm_next     = w_running && w_next_running && ({1'b0, contagem} < r_duty_active);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_duty_active   <= '0;
      r_duty_pending  <= '0;
      r_pending_valid <= 1'b0;
    end else if (w_apply) begin
      r_duty_active   <= r_duty_pending;
      r_pending_valid <= 1'b0;
    end else if (w_accept) begin
      r_duty_pending  <= cfg_duty;
      r_pending_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pwm         <= 1'b0;
      r_period_done <= 1'b0;
      r_period_cnt  <= '0;
    end else begin
      r_pwm         <= w_pwm_next;
      r_period_done <= fim && w_running;
      if ((r_state == S_IDLE) && (w_state_next == S_ARMED)) begin
        r_period_cnt <= '0;
      end else if (fim && w_running) begin
        r_period_cnt <= r_period_cnt + c_pcnt_one;
      end
    end
  end

  assign cfg_ready   = !r_pending_valid;
  assign pwm         = r_pwm;
  assign period_done = r_period_done;
  assign busy        = (r_state != S_IDLE);
  assign period_cnt  = r_period_cnt;

endmodule
`default_nettype wire
